// File: rtl/strobe_pkg.sv
// strobe_pkg: shared defaults and helpers for the strobe_gen clock-enable generator.
//   ACC_W_DEF   - default accumulator width (rate resolution 1/2^ACC_W)
//   INC_PIXEL   - 25 MHz pixel enable from a 100 MHz clk (1/4 rate)
//   INC_TICK    - game-logic tick increment
//   INC_RST_DEF - packed reset increments for the default two-channel build
//   ch_width()  - width of the channel-select field, never less than 1
package strobe_pkg;

    localparam int unsigned ACC_W_DEF = 16;

    localparam logic [15:0] INC_PIXEL = 16'h4000;
    localparam logic [15:0] INC_TICK  = 16'h0040;

    // Channel 0 sits in the low slice.
    localparam logic [31:0] INC_RST_DEF = {INC_TICK, INC_PIXEL};

    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/strobe_chan.sv
// strobe_chan: one phase-accumulator channel of strobe_gen.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   en         - accumulate enable
//   phase_clr  - clears acc, stb and tog (pending update is kept)
//   cfg_wr     - accepted increment update for this channel
//   cfg_inc    - new increment, held in the shadow register until applied
//   pending    - shadow holds an update not yet applied
//   stb        - registered one-cycle strobe on each accumulator carry
//   tog        - flips on each strobe
module strobe_chan
    import strobe_pkg::*;
#(
    parameter int unsigned      ACC_W   = ACC_W_DEF,
    parameter logic [ACC_W-1:0] INC_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             phase_clr,
    input  logic             cfg_wr,
    input  logic [ACC_W-1:0] cfg_inc,
    output logic             pending,
    output logic             stb,
    output logic             tog
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] inc_q;
    logic [ACC_W-1:0] shadow_q;
    logic             pending_q;
    logic             stb_q;
    logic             tog_q;

    logic [ACC_W:0]   sum;
    logic             carry;
    logic             apply;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, inc_q};
        carry = en && !phase_clr && sum[ACC_W];
        // Updates land only on a period boundary so no runt period is produced.
        // A stopped channel (inc 0) never reaches a boundary, so it applies at once.
        apply = pending_q && (carry || (inc_q == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            inc_q     <= INC_RST;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            stb_q     <= 1'b0;
            tog_q     <= 1'b0;
        end else begin
            if (phase_clr) begin
                acc_q <= '0;
                stb_q <= 1'b0;
                tog_q <= 1'b0;
            end else if (en) begin
                acc_q <= sum[ACC_W-1:0];
                stb_q <= carry;
                tog_q <= tog_q ^ carry;
            end else begin
                stb_q <= 1'b0;
            end

            // cfg_wr is only granted while not pending, so it never collides with apply.
            if (apply) begin
                inc_q     <= shadow_q;
                pending_q <= 1'b0;
            end else if (cfg_wr) begin
                shadow_q  <= cfg_inc;
                pending_q <= 1'b1;
            end
        end
    end

    assign pending = pending_q;
    assign stb     = stb_q;
    assign tog     = tog_q;

endmodule

// File: rtl/strobe_gen.sv
// strobe_gen: multi-channel fractional clock-enable generator.
// Each channel strobes at an average rate of inc/2^ACC_W of clk; increments
// are retuned at runtime through a valid/ready port without glitches.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   en         - global accumulate enable
//   phase_clr  - per-channel accumulator clear
//   cfg_valid  - increment update request
//   cfg_ch     - target channel; out-of-range channels are accepted and dropped
//   cfg_inc    - new increment
//   cfg_ready  - update can be accepted (target channel has nothing pending)
//   stb        - one-cycle strobe per channel
//   tog        - square wave per channel, flips on each strobe
module strobe_gen
    import strobe_pkg::*;
#(
    parameter int unsigned              ACC_W   = ACC_W_DEF,
    parameter int unsigned              NCH     = 2,
    parameter logic [NCH*ACC_W-1:0]     INC_RST = INC_RST_DEF,
    localparam int unsigned             CH_W    = ch_width(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NCH-1:0]   phase_clr,
    input  logic             cfg_valid,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [ACC_W-1:0] cfg_inc,
    output logic             cfg_ready,
    output logic [NCH-1:0]   stb,
    output logic [NCH-1:0]   tog
);

    logic [NCH-1:0] pending;
    logic [NCH-1:0] cfg_wr;

    // Channels outside 0..NCH-1 keep the default of 1 so such requests drain.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pending[i];
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign cfg_wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

        strobe_chan #(
            .ACC_W   (ACC_W),
            .INC_RST (INC_RST[i*ACC_W +: ACC_W])
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .phase_clr (phase_clr[i]),
            .cfg_wr    (cfg_wr[i]),
            .cfg_inc   (cfg_inc),
            .pending   (pending[i]),
            .stb       (stb[i]),
            .tog       (tog[i])
        );
    end

endmodule

// File: tb/tb_strobe_gen.sv
// tb_strobe_gen: self-checking bench for strobe_gen (3 channels so that an
// out-of-range cfg_ch is expressible and channel 2 starts stopped).
module tb_strobe_gen;

    localparam int unsigned ACC_W = 16;
    localparam int unsigned NCH   = 3;
    localparam int unsigned CH_W  = 2;
    localparam logic [NCH*ACC_W-1:0] INC_RST = {16'h0000, 16'h0040, 16'h4000};
    localparam int unsigned MOD   = 1 << ACC_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [NCH-1:0]   phase_clr;
    logic             cfg_valid;
    logic [CH_W-1:0]  cfg_ch;
    logic [ACC_W-1:0] cfg_inc;
    logic             cfg_ready;
    logic [NCH-1:0]   stb;
    logic [NCH-1:0]   tog;

    always #5 clk = ~clk;

    strobe_gen #(
        .ACC_W   (ACC_W),
        .NCH     (NCH),
        .INC_RST (INC_RST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .phase_clr (phase_clr),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_ready (cfg_ready),
        .stb       (stb),
        .tog       (tog)
    );

    typedef struct packed {
        logic [NCH-1:0] stb;
        logic [NCH-1:0] tog;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state
    int unsigned m_acc[NCH];
    int unsigned m_inc[NCH];
    int unsigned m_shadow[NCH];
    bit          m_pend[NCH];
    bit          m_stb[NCH];
    bit          m_tog[NCH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        logic [NCH*ACC_W-1:0] rv;
        rv = INC_RST;
        for (int i = 0; i < NCH; i++) begin
            m_acc[i]    = 0;
            m_inc[i]    = rv[i*ACC_W +: ACC_W];
            m_shadow[i] = 0;
            m_pend[i]   = 0;
            m_stb[i]    = 0;
            m_tog[i]    = 0;
        end
    endfunction

    function automatic bit model_ready();
        if (int'(cfg_ch) >= NCH) return 1'b1;
        return !m_pend[cfg_ch];
    endfunction

    function automatic void model_advance();
        for (int i = 0; i < NCH; i++) begin
            bit          xfer;
            bit          carry;
            int unsigned old_inc;
            int unsigned s;
            xfer    = cfg_valid && (int'(cfg_ch) == i) && !m_pend[i];
            carry   = 0;
            old_inc = m_inc[i];
            if (phase_clr[i]) begin
                m_acc[i] = 0;
                m_stb[i] = 0;
                m_tog[i] = 0;
            end else if (en) begin
                s        = m_acc[i] + m_inc[i];
                carry    = (s >= MOD);
                m_acc[i] = s % MOD;
                m_stb[i] = carry;
                m_tog[i] = m_tog[i] ^ carry;
            end else begin
                m_stb[i] = 0;
            end
            if (m_pend[i] && (carry || old_inc == 0)) begin
                m_inc[i]  = m_shadow[i];
                m_pend[i] = 0;
            end else if (xfer) begin
                m_shadow[i] = cfg_inc;
                m_pend[i]   = 1;
            end
        end
    endfunction

    // One clock: check ready, predict, push, clock, pop and compare.
    task automatic step();
        exp_t e;
        #1;
        check_eq("cfg_ready", cfg_ready, model_ready());
        if (rst) model_reset();
        else model_advance();
        for (int i = 0; i < NCH; i++) begin
            e.stb[i] = m_stb[i];
            e.tog[i] = m_tog[i];
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("stb", stb, e.stb);
        check_eq("tog", tog, e.tog);
    endtask

    task automatic wait_stb(input int ch, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!stb[ch] && n < limit);
        check_eq("wait_stb", stb[ch], 1);
    endtask

    initial begin
        int n;
        int c1;
        int cnt;
        int q0[$];

        rst       = 1'b1;
        en        = 1'b0;
        phase_clr = '0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_inc   = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        step();
        check_eq("rst_stb", stb, 0);
        check_eq("rst_tog", tog, 0);
        check_eq("rst_ready", cfg_ready, 1);

        // Free run from reset release: ch0 every 4 edges, ch1 4 times in 4096.
        rst = 1'b0;
        en  = 1'b1;
        c1  = 0;
        for (int k = 1; k <= 4096; k++) begin
            step();
            if (stb[0] && k <= 16) q0.push_back(k);
            if (stb[1]) c1++;
        end
        check_eq("ch0_first16_cnt", q0.size(), 4);
        for (int j = 0; j < q0.size(); j++) check_eq("ch0_edge", q0[j], 4 * (j + 1));
        check_eq("ch1_4096_cnt", c1, 4);

        // en low for 5 cycles mid-period stretches the period by 5.
        wait_stb(0, 16, n);
        step();
        en  = 1'b0;
        cnt = 0;
        repeat (5) begin
            step();
            if (stb[0]) cnt++;
        end
        check_eq("en_low_stb", cnt, 0);
        en = 1'b1;
        wait_stb(0, 16, n);
        check_eq("en_stretch", 6 + n, 9);

        // phase_clr: acc and tog cleared, next strobe 4 cycles later.
        wait_stb(0, 16, n);
        step();
        phase_clr = 3'b001;
        step();
        phase_clr = '0;
        check_eq("clr_tog", tog[0], 0);
        wait_stb(0, 16, n);
        check_eq("clr_period", n, 4);

        // Retune ch0 4000 -> 2000 mid-period.
        wait_stb(0, 16, n);
        step();
        cfg_ch    = 2'd0;
        cfg_inc   = 16'h2000;
        cfg_valid = 1'b1;
        #1;
        check_eq("rt_ready_pre", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        check_eq("rt_ready_pend", cfg_ready, 0);
        wait_stb(0, 16, n);
        check_eq("rt_old_period", 2 + n, 4);
        check_eq("rt_ready_post", cfg_ready, 1);
        wait_stb(0, 16, n);
        check_eq("rt_new_period", n, 8);

        // Stopped ch2 (inc 0) takes 8000 on the next cycle.
        cfg_ch    = 2'd2;
        cfg_inc   = 16'h8000;
        cfg_valid = 1'b1;
        #1;
        check_eq("z_ready_pre", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        check_eq("z_ready_pend", cfg_ready, 0);
        step();
        check_eq("z_ready_applied", cfg_ready, 1);
        wait_stb(2, 8, n);
        check_eq("z_first_stb", n, 2);

        // Out-of-range channel: accepted and dropped.
        cfg_ch    = 2'd3;
        cfg_inc   = 16'h1234;
        cfg_valid = 1'b1;
        #1;
        check_eq("oor_ready", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        repeat (8) step();

        // ch2 at 5555: strobes = floor(sum of increments / 2^16).
        cfg_ch    = 2'd2;
        cfg_inc   = 16'h5555;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        n = 0;
        while (!cfg_ready && n < 8) begin
            step();
            n++;
        end
        check_eq("f_applied", cfg_ready, 1);
        cnt = 0;
        for (int k = 0; k < 16384; k++) begin
            step();
            if (stb[2]) cnt++;
        end
        check_eq("f_count", cnt, (16384 * 32'h5555) / MOD);

        // Reset with a pending update on ch1.
        cfg_ch    = 2'd1;
        cfg_inc   = 16'h1000;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check_eq("r_pending", cfg_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("r_stb", stb, 0);
        check_eq("r_tog", tog, 0);
        check_eq("r_ready", cfg_ready, 1);
        wait_stb(0, 16, n);
        check_eq("r_first_stb", n, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
